// File: rtl/snake_body.sv
// ---------------------------------------------------------------------------
// snake_body
//
// Keeps the ordered list of snake body segments, advances it once per video
// frame, grows it on request, detects the head running into its own body and
// tells the colour stage whether the current pixel is covered by the body.
//
// Once per frame (falling edge of frame_vs) the block steps through:
//   IDLE  -> SHIFT : every segment takes its predecessor's position, segment 0
//                    takes the current head position; a pending grow adds one
//                    segment (saturating at MAX_LEN).
//   SHIFT -> CHECK : segments 1..length-1 are compared with segment 0, one per
//                    clock; any exact match sets the sticky self_hit flag.
//   CHECK -> IDLE  : when the last active segment has been compared.
//
// Ports
//   Clk            system clock, all state updates on its rising edge
//   Reset          synchronous, active-high
//   frame_vs       VGA vertical sync (active-low pulse), same clock domain
//   HeadX, HeadY   current head position (10 bits each)
//   grow           one-clock request for one more segment
//   DrawX, DrawY   pixel currently being drawn (10 bits each)
//   body_on        pixel lies inside an active segment (1 clock after DrawX/Y)
//   length         number of active segments
//   self_hit       sticky head/body collision flag, cleared only by Reset
//   busy           high while in SHIFT or CHECK
// ---------------------------------------------------------------------------
module snake_body #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int SEG_SIZE = 8,
  parameter int START_X  = 320,
  parameter int START_Y  = 240
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_vs,
  input  logic [9:0] HeadX,
  input  logic [9:0] HeadY,
  input  logic       grow,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       body_on,
  output logic [5:0] length,
  output logic       self_hit,
  output logic       busy
);

  localparam logic [5:0]  MAX_LEN_L  = 6'(MAX_LEN);
  localparam logic [5:0]  INIT_LEN_L = 6'(INIT_LEN);
  localparam logic [10:0] SEG_SIZE_L = 11'(SEG_SIZE);
  localparam logic [9:0]  START_X_L  = 10'(START_X);
  localparam logic [9:0]  START_Y_L  = 10'(START_Y);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       fvs_q, fvs_d;
  logic       tick_block_q, tick_block_d;
  logic       grow_pending_q, grow_pending_d;
  logic [5:0] length_q, length_d;
  logic [5:0] idx_q, idx_d;
  logic       self_hit_q, self_hit_d;
  logic       body_on_q, body_on_d;

  logic [9:0] seg_x_q [MAX_LEN];
  logic [9:0] seg_y_q [MAX_LEN];
  logic [9:0] seg_x_d [MAX_LEN];
  logic [9:0] seg_y_d [MAX_LEN];

  logic [MAX_LEN-1:0] hit_vec;
  logic [MAX_LEN-1:0] pix_vec;
  logic               tick;

  // Falling edge of frame_vs. tick_block_q is high only in the first cycle
  // after Reset deasserts, so a frame_vs held low through reset does not
  // look like a fresh falling edge.
  assign tick = fvs_q & ~frame_vs & ~tick_block_q;

  assign fvs_d        = frame_vs;
  assign tick_block_d = 1'b0;

  // -------------------------------------------------------------------------
  // Segment storage: a shift register of positions, advanced only in SHIFT.
  // Kept in flops because body_on needs every segment in parallel.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
      if (gi == 0) begin : g_head
        always_comb begin
          seg_x_d[gi] = seg_x_q[gi];
          seg_y_d[gi] = seg_y_q[gi];
          if (state_q == ST_SHIFT) begin
            seg_x_d[gi] = HeadX;
            seg_y_d[gi] = HeadY;
          end
        end
        // Segment 0 is the reference, never compared with itself.
        assign hit_vec[gi] = 1'b0;
      end else begin : g_tail
        always_comb begin
          seg_x_d[gi] = seg_x_q[gi];
          seg_y_d[gi] = seg_y_q[gi];
          if (state_q == ST_SHIFT) begin
            seg_x_d[gi] = seg_x_q[gi-1];
            seg_y_d[gi] = seg_y_q[gi-1];
          end
        end
        // Only the segment currently addressed by the scan, and only if it
        // is active, can report a collision.
        assign hit_vec[gi] = (6'(gi) == idx_q) && (6'(gi) < length_q) &&
                             (seg_x_q[gi] == seg_x_q[0]) &&
                             (seg_y_q[gi] == seg_y_q[0]);
      end

      // Pixel coverage, widened to 11 bits so seg + SEG_SIZE cannot wrap.
      assign pix_vec[gi] = (6'(gi) < length_q) &&
                           ({1'b0, DrawX} >= {1'b0, seg_x_q[gi]}) &&
                           ({1'b0, DrawX} <  ({1'b0, seg_x_q[gi]} + SEG_SIZE_L)) &&
                           ({1'b0, DrawY} >= {1'b0, seg_y_q[gi]}) &&
                           ({1'b0, DrawY} <  ({1'b0, seg_y_q[gi]} + SEG_SIZE_L));

      always_ff @(posedge Clk) begin
        if (Reset) begin
          seg_x_q[gi] <= START_X_L;
          seg_y_q[gi] <= START_Y_L;
        end else begin
          seg_x_q[gi] <= seg_x_d[gi];
          seg_y_q[gi] <= seg_y_d[gi];
        end
      end
    end
  endgenerate

  assign body_on_d = |pix_vec;

  // -------------------------------------------------------------------------
  // Control FSM: next state and datapath control.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    length_d       = length_q;
    grow_pending_d = grow_pending_q | grow;
    self_hit_d     = self_hit_q;

    case (state_q)
      ST_IDLE: begin
        // Ticks outside IDLE are dropped, never queued.
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        state_d = ST_CHECK;
        idx_d   = 6'd1;
        if (grow_pending_q && (length_q < MAX_LEN_L)) begin
          length_d = length_q + 6'd1;
        end
        // The pending request is consumed here whether or not it was
        // honoured; a grow pulse landing in this very cycle re-arms it.
        grow_pending_d = grow;
      end

      ST_CHECK: begin
        if (|hit_vec) begin
          self_hit_d = 1'b1;
        end
        // Last index is length-1; with length 1 this is true on the first
        // cycle, giving a single cycle with no active comparison.
        if ((idx_q + 6'd1) >= length_q) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      fvs_q          <= 1'b1;
      tick_block_q   <= 1'b1;
      grow_pending_q <= 1'b0;
      length_q       <= INIT_LEN_L;
      idx_q          <= 6'd1;
      self_hit_q     <= 1'b0;
      body_on_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      fvs_q          <= fvs_d;
      tick_block_q   <= tick_block_d;
      grow_pending_q <= grow_pending_d;
      length_q       <= length_d;
      idx_q          <= idx_d;
      self_hit_q     <= self_hit_d;
      body_on_q      <= body_on_d;
    end
  end

  assign body_on  = body_on_q;
  assign length   = length_q;
  assign self_hit = self_hit_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snake_body.sv
// ---------------------------------------------------------------------------
// tb_snake_body
//
// Directed bench for snake_body with default parameters (MAX_LEN 32,
// INIT_LEN 3, SEG_SIZE 8, start position 320,240). Inputs change 1 ns after
// a rising edge and outputs are sampled at the same point, so every sample
// reflects the state committed by the preceding edge.
// ---------------------------------------------------------------------------
module tb_snake_body;

  logic       Clk;
  logic       Reset;
  logic       frame_vs;
  logic [9:0] HeadX;
  logic [9:0] HeadY;
  logic       grow;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       body_on;
  logic [5:0] length;
  logic       self_hit;
  logic       busy;

  int checks;
  int errors;

  snake_body dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_vs (frame_vs),
    .HeadX    (HeadX),
    .HeadY    (HeadY),
    .grow     (grow),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .body_on  (body_on),
    .length   (length),
    .self_hit (self_hit),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a pixel, let one edge pass, compare body_on.
  task automatic probe(input string tag, input int x, input int y, input logic exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    check(tag, {31'd0, body_on}, {31'd0, exp});
  endtask

  // One frame: frame_vs low for one cycle with head/grow presented, then
  // count the cycles busy stays high (bounded).
  task automatic do_tick(input int hx, input int hy, input logic g, output int cyc);
    HeadX    = 10'(hx);
    HeadY    = 10'(hy);
    grow     = g;
    frame_vs = 1'b0;
    step();
    grow     = 1'b0;
    frame_vs = 1'b1;
    cyc      = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      step();
    end
    $display("tick head=(%0d,%0d) grow=%0d busy_cycles=%0d length=%0d self_hit=%0d",
             hx, hy, g, cyc, length, self_hit);
  endtask

  initial begin
    int cyc;
    int exp_len;
    logic exp_on;

    checks   = 0;
    errors   = 0;
    Reset    = 1'b1;
    frame_vs = 1'b1;
    HeadX    = 10'd320;
    HeadY    = 10'd240;
    grow     = 1'b0;
    DrawX    = 10'd0;
    DrawY    = 10'd0;

    // ---- Reset state ------------------------------------------------------
    step(); step(); step();
    check("rst_length",   32'(length),  32'd3);
    check("rst_busy",     32'(busy),    32'd0);
    check("rst_self_hit", 32'(self_hit), 32'd0);
    check("rst_body_on",  32'(body_on), 32'd0);
    Reset = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);

    // ---- Pixel sweep: only 320..327 x 240..247 is covered -----------------
    for (int x = 314; x <= 333; x++) begin
      exp_on = (x >= 320 && x <= 327);
      probe("sweep_x", x, 244, exp_on);
    end
    for (int y = 236; y <= 251; y++) begin
      exp_on = (y >= 240 && y <= 247);
      probe("sweep_y", 323, y, exp_on);
    end
    probe("corner_out", 328, 248, 1'b0);
    // Latency: the new pixel must not show before the next edge.
    DrawX = 10'd323;
    DrawY = 10'd244;
    #1;
    check("latency_before_edge", 32'(body_on), 32'd0);
    step();
    check("latency_after_edge", 32'(body_on), 32'd1);
    $display("pixel sweep done");

    // ---- Single tick, head at (100,50) ------------------------------------
    do_tick(100, 50, 1'b0, cyc);
    check("t1_busy_cycles", 32'(cyc), 32'd3);
    check("t1_seg0_x", 32'(dut.seg_x_q[0]), 32'd100);
    check("t1_seg0_y", 32'(dut.seg_y_q[0]), 32'd50);
    check("t1_seg1_x", 32'(dut.seg_x_q[1]), 32'd320);
    check("t1_seg1_y", 32'(dut.seg_y_q[1]), 32'd240);
    check("t1_self_hit", 32'(self_hit), 32'd0);
    check("t1_length", 32'(length), 32'd3);
    probe("t1_pix_head",  100, 50, 1'b1);
    probe("t1_pix_far",   107, 57, 1'b1);
    probe("t1_pix_right", 108, 50, 1'b0);
    probe("t1_pix_old",   320, 240, 1'b1);

    // ---- Grow in the same cycle as the tick: 3 -> 4 in SHIFT --------------
    HeadX    = 10'd200;
    HeadY    = 10'd100;
    grow     = 1'b1;
    frame_vs = 1'b0;
    step();                               // tick seen, now in SHIFT
    grow     = 1'b0;
    frame_vs = 1'b1;
    check("grow_shift_busy",   32'(busy),   32'd1);
    check("grow_shift_length", 32'(length), 32'd3);
    step();                               // SHIFT committed
    check("grow_after_shift_length", 32'(length), 32'd4);
    cyc = 1;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      step();
    end
    $display("grow tick busy_cycles=%0d length=%0d", cyc, length);
    check("grow_busy_cycles", 32'(cyc), 32'd4);
    check("grow_self_hit", 32'(self_hit), 32'd0);

    // ---- Second tick while busy is ignored --------------------------------
    HeadX    = 10'd300;
    HeadY    = 10'd200;
    frame_vs = 1'b0;
    step();                               // SHIFT
    frame_vs = 1'b1;
    step();                               // CHECK idx 1
    frame_vs = 1'b0;
    step();                               // falling edge seen in CHECK
    frame_vs = 1'b1;
    check("busy_tick_in_check", 32'(busy), 32'd1);
    step();
    step();
    check("busy_tick_done", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_tick_not_queued", 32'(busy), 32'd0);
    end
    check("busy_tick_seg0_x", 32'(dut.seg_x_q[0]), 32'd300);
    check("busy_tick_seg1_x", 32'(dut.seg_x_q[1]), 32'd200);
    check("busy_tick_seg1_y", 32'(dut.seg_y_q[1]), 32'd100);
    check("busy_tick_seg2_x", 32'(dut.seg_x_q[2]), 32'd100);
    check("busy_tick_self_hit", 32'(self_hit), 32'd0);
    $display("ignored tick: seg0=(%0d,%0d) seg1=(%0d,%0d)",
             dut.seg_x_q[0], dut.seg_y_q[0], dut.seg_x_q[1], dut.seg_y_q[1]);

    // ---- Self collision with length 5 -------------------------------------
    do_tick(8, 0, 1'b1, cyc);
    check("loop_length", 32'(length), 32'd5);
    check("loop_busy_cycles", 32'(cyc), 32'd5);
    do_tick(16, 0, 1'b0, cyc);
    do_tick(16, 8, 1'b0, cyc);
    do_tick(8, 8, 1'b0, cyc);
    check("loop_no_hit_yet", 32'(self_hit), 32'd0);
    do_tick(8, 0, 1'b0, cyc);
    check("loop_hit", 32'(self_hit), 32'd1);
    for (int i = 0; i < 10; i++) begin
      do_tick(400 + 8 * i, 300, 1'b0, cyc);
      check("hit_sticky", 32'(self_hit), 32'd1);
    end
    check("sticky_length", 32'(length), 32'd5);

    // ---- Saturation: 40 grows with 40 ticks -------------------------------
    for (int i = 0; i < 40; i++) begin
      exp_len = 5 + i + 1;
      if (exp_len > 32) exp_len = 32;
      do_tick(600 + 8 * i, 400, 1'b1, cyc);
      check("sat_length", 32'(length), 32'(exp_len));
      check("sat_busy_cycles", 32'(cyc), 32'(exp_len));
    end

    // ---- Reset asserted mid-CHECK -----------------------------------------
    HeadX    = 10'd50;
    HeadY    = 10'd60;
    frame_vs = 1'b0;
    step();                               // SHIFT
    frame_vs = 1'b1;
    step(); step(); step(); step();       // inside a 31-cycle CHECK
    check("midcheck_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    step();
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_length",   32'(length),   32'd3);
    check("midrst_self_hit", 32'(self_hit), 32'd0);
    check("midrst_body_on",  32'(body_on),  32'd0);
    check("midrst_seg0_x",   32'(dut.seg_x_q[0]), 32'd320);
    $display("reset mid-check: busy=%0d length=%0d self_hit=%0d", busy, length, self_hit);

    // ---- No tick in the cycle Reset deasserts -----------------------------
    frame_vs = 1'b0;
    step();
    Reset = 1'b0;
    step();
    check("rst_release_no_tick", 32'(busy), 32'd0);
    step();
    check("rst_release_still_idle", 32'(busy), 32'd0);
    frame_vs = 1'b1;
    step();
    check("rst_release_length", 32'(length), 32'd3);
    probe("final_pix_start", 320, 240, 1'b1);
    probe("final_pix_old_head", 50, 60, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 32, meaning capacity of the segment buffer in segments.
REQ-002 SHALL provide parameter INIT_LEN, default 3, meaning segment count after reset; 1 <= INIT_LEN <= MAX_LEN.
REQ-003 SHALL provide parameter SEG_SIZE, default 8, meaning segment square edge length in pixels.
REQ-004 SHALL provide parameters START_X and START_Y, defaults 320 and 240, meaning the reset position of every segment.
REQ-005 Clk  input  1  system clock (50 MHz); the only clock; all state is updated on its rising edge.
REQ-006 Reset  input  1  synchronous reset, active-high.
REQ-007 frame_vs  input  1  VGA vertical sync from vga_controller, same Clk domain, active-low pulse.
REQ-008 HeadX, HeadY  input  10 each  current head position from the snake motion block.
REQ-009 grow  input  1  one-Clk pulse requesting one additional segment.
REQ-010 DrawX, DrawY  input  10 each  current pixel coordinate from vga_controller.
REQ-011 body_on  output  1  current pixel lies inside an active segment; consumed by the colour stage.
REQ-012 length  output  6  number of active segments.
REQ-013 self_hit  output  1  sticky flag: head collided with its own body.
REQ-014 busy  output  1  high while the state machine is not in IDLE.

Function
REQ-015 SHALL detect a frame tick as a 1->0 transition of frame_vs, using one registered copy of frame_vs; this gives exactly one tick per frame.
REQ-016 SHALL implement the states IDLE, SHIFT, and CHECK.
- IDLE -> SHIFT on a tick.
- SHIFT -> CHECK after 1 cycle.
- CHECK -> IDLE when the scan completes.
REQ-017 In SHIFT, SHALL perform seg[i] <= seg[i-1] for i = MAX_LEN-1 down to 1, and seg[0] <= {HeadX, HeadY} sampled in that cycle.
REQ-018 In SHIFT, if grow_pending = 1 and length < MAX_LEN, SHALL increment length by 1; grow_pending SHALL clear in SHIFT in every case.
REQ-019 grow = 1 SHALL set grow_pending; when grow and a tick occur in the same cycle, the grow SHALL apply to that tick's SHIFT.
REQ-020 A grow at length = MAX_LEN SHALL be discarded; length saturates at MAX_LEN and never wraps.
REQ-021 CHECK SHALL scan index k = 1 .. length-1, one index per Clk, comparing seg[0] with seg[k] for exact equality on both axes; any match SHALL set self_hit.
REQ-022 When length = 1, CHECK SHALL last 1 cycle with no comparisons; otherwise CHECK SHALL last length-1 cycles.
REQ-023 self_hit SHALL stay at 1 until Reset.
REQ-024 A tick arriving while busy = 1 SHALL be ignored; it SHALL NOT be queued.
REQ-025 busy SHALL equal 1 exactly in SHIFT and CHECK.
REQ-026 body_on SHALL be registered with 1 Clk latency from DrawX/DrawY.
- body_on = 1 iff some i < length satisfies segX <= DrawX < segX+SEG_SIZE and segY <= DrawY < segY+SEG_SIZE.
- The additions SHALL be computed at 11 bits so they never wrap.
REQ-027 Segments with index >= length SHALL never affect body_on or self_hit.
REQ-028 length SHALL change only in SHIFT or on Reset.

Reset
REQ-029 On Reset = 1 at a Clk edge, in any state including mid-SHIFT or mid-CHECK, the block SHALL apply all of the following:
- state = IDLE
- every seg = (START_X, START_Y)
- length = INIT_LEN
- grow_pending = 0
- self_hit = 0, body_on = 0, busy = 0
- the frame_vs history register = 1
REQ-030 No tick SHALL be detected in the cycle Reset deasserts, even if frame_vs = 0.

Verification
REQ-031 Reset, then pixel sweep -> length = 3, self_hit = 0; body_on = 1 only for DrawX 320..327 and DrawY 240..247, appearing 1 Clk after the pixel.
REQ-032 Head at (100,50), one tick -> seg[0] = (100,50), seg[1] = (320,240); busy high for 3 cycles (SHIFT + 2 CHECK); self_hit = 0.
REQ-033 grow pulse in the same cycle as a tick -> length 3 -> 4 in SHIFT; 40 grows with 40 ticks -> length saturates at 32 and never wraps to 0.
REQ-034 Drive the head through (8,0), (16,0), (16,8), (8,8), (8,0) over successive ticks with length 5 -> self_hit = 1 after the last CHECK, and it stays 1 over the next 10 ticks.
REQ-035 Second tick injected while busy = 1 -> segments shift exactly once.
REQ-036 Reset asserted mid-CHECK -> next cycle shows state IDLE, busy = 0, length = 3, self_hit = 0.
